// File: rtl/pc_gen_bp_if.sv
// Fetch PC generator bus: IF/ID back-pressure, EX redirect, EX branch update,
// and the fetch address/prediction returned to IF.
//   master: drives stall, redirect_*, upd_*; observes pc, pred_taken, pred_target
//   slave : the PC generator itself
interface pc_gen_bp_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic [ADDR_W-1:0] pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  modport master (
    output stall, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  pc, pred_taken, pred_target
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output pc, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_gen_bp.sv
// Fetch-stage PC generator with a direct-mapped BTB of 2-bit direction counters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : stall, redirect_valid/redirect_pc (EX correction),
//                upd_valid/upd_pc/upd_taken/upd_target (EX resolve),
//                pc (registered fetch address), pred_taken/pred_target
//                (combinational lookup on pc)
// Next PC priority: redirect, stall, BTB prediction, pc+4.
module pc_gen_bp #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       BTB_ENTRIES = 64,
  parameter logic [1:0]        CTR_INIT    = 2'b01
) (
  input logic         clk,
  input logic         rst_n,
  pc_gen_bp_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  logic [ADDR_W-1:0]      pc_q;
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [1:0]             ctr_q [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [ADDR_W-1:0]      tgt_q [BTB_ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic              pred_taken_c;
  logic [ADDR_W-1:0] pred_target_c;
  logic [ADDR_W-1:0] pc_next;

  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic [1:0]        ctr_cur;
  logic [1:0]        ctr_upd;

  // Byte-offset bits never take part in index/tag selection.
  logic unused_lo_bits;
  assign unused_lo_bits = ^{bus.upd_pc[1:0], pc_q[1:0]};

  assign lk_idx  = pc_q[IDX_W+1:2];
  assign lk_tag  = pc_q[ADDR_W-1:IDX_W+2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];

  // Lookup on the current fetch address; sees pre-update contents.
  always_comb begin
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_c  = lk_hit && ctr_q[lk_idx][1];
    pred_target_c = pred_taken_c ? tgt_q[lk_idx] : '0;
  end

  // Next fetch address selection.
  always_comb begin
    pc_next = pc_q + ADDR_W'(4);
    if (bus.redirect_valid) begin
      pc_next = bus.redirect_pc;
    end else if (bus.stall) begin
      pc_next = pc_q;
    end else if (pred_taken_c) begin
      pc_next = pred_target_c;
    end
  end

  // Saturating counter step for the entry addressed by the update.
  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    ctr_cur = ctr_q[upd_idx];
    ctr_upd = ctr_cur;
    if (bus.upd_taken) begin
      if (ctr_cur != 2'b11) ctr_upd = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_upd = ctr_cur - 2'b01;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // Valid bits and counters: reset state, hit-train or taken-miss allocate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(BTB_ENTRIES); i++) ctr_q[i] <= CTR_INIT;
    end else if (bus.upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_upd;
      end else if (bus.upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target storage is unreset; it is only meaningful behind valid.
  always_ff @(posedge clk) begin
    if (bus.upd_valid && bus.upd_taken) begin
      tgt_q[upd_idx] <= bus.upd_target;
      if (!upd_hit) tag_q[upd_idx] <= upd_tag;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = pred_taken_c;
  assign bus.pred_target = pred_target_c;

endmodule

// File: tb/tb_pc_gen_bp.sv
// Bench for pc_gen_bp: directed scenarios plus random traffic, all checked
// against an address-arithmetic model of the BTB and next-PC rules.
module tb_pc_gen_bp;

  localparam int unsigned AW  = 32;
  localparam int unsigned NE  = 64;
  localparam logic [31:0] RPC = 32'h100;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  pc_gen_bp_if #(.ADDR_W(AW)) bus ();

  pc_gen_bp #(
    .ADDR_W(AW), .RESET_PC(RPC), .BTB_ENTRIES(NE), .CTR_INIT(2'b01)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // Reference model state
  bit          m_valid [NE];
  int          m_ctr   [NE];
  logic [31:0] m_tag   [NE];
  logic [31:0] m_tgt   [NE];
  logic [31:0] m_pc;

  logic [31:0] pool [10] = '{32'h40, 32'h140, 32'h240, 32'h80, 32'h180,
                             32'h300, 32'h304, 32'h308, 32'h200, 32'h44};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % NE);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> 8;
  endfunction

  function automatic bit m_pt(input logic [31:0] a);
    int i = idx_of(a);
    return m_valid[i] && (m_tag[i] == tag_of(a)) && (m_ctr[i] >= 2);
  endfunction

  task automatic m_reset();
    m_pc = RPC;
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic drive_idle();
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;
    bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_taken = 0; bus.upd_target = '0;
  endtask

  // One clock: drive at negedge, check outputs, advance model, wait to next negedge.
  task automatic go(input logic st, input logic rv, input logic [31:0] rpc,
                    input logic uv, input logic [31:0] upc, input logic ut,
                    input logic [31:0] utg);
    bit          pt;
    logic [31:0] ptg;
    logic [31:0] nxt;
    int          i;
    bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_taken = ut; bus.upd_target = utg;
    pt  = m_pt(m_pc);
    ptg = pt ? m_tgt[idx_of(m_pc)] : 32'h0;
    chk("pc", bus.pc, m_pc);
    chk("pred_taken", 32'(bus.pred_taken), 32'(pt));
    chk("pred_target", bus.pred_target, ptg);
    if (rv)      nxt = rpc;
    else if (st) nxt = m_pc;
    else if (pt) nxt = ptg;
    else         nxt = m_pc + 32'd4;
    if (uv) begin
      i = idx_of(upc);
      if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
        if (ut) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = utg;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ut) begin
        m_valid[i] = 1'b1; m_tag[i] = tag_of(upc); m_tgt[i] = utg; m_ctr[i] = 2;
      end
    end
    m_pc = nxt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();            go(0, 0, 0, 0, 0, 0, 0);   endtask
  task automatic redir(input logic [31:0] a); go(0, 1, a, 0, 0, 0, 0); endtask
  task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] g);
    go(0, 0, 0, 1, a, t, g);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    #1;
    m_reset();
    chk("rst_pc", bus.pc, RPC);
    chk("rst_pred_taken", 32'(bus.pred_taken), 32'h0);
    chk("rst_pred_target", bus.pred_target, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic        st, rv, uv, ut;
  logic [31:0] rpc, upc, utg;

  initial begin
    n_chk = 0; n_bad = 0;
    rst_n = 1'b0;
    drive_idle();
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("init_pc", bus.pc, RPC);
    rst_n = 1'b1;

    // Sequential, stall and wrap
    redir(32'h0);
    chk("seq0", bus.pc, 32'h0);
    idle(); chk("seq4", bus.pc, 32'h4);
    idle(); chk("seq8", bus.pc, 32'h8);
    idle(); chk("seqC", bus.pc, 32'hC);
    for (int k = 0; k < 3; k++) begin
      go(1, 0, 0, 0, 0, 0, 0);
      chk("stall_hold", bus.pc, 32'hC);
    end
    redir(32'hFFFF_FFFC);
    idle(); chk("wrap", bus.pc, 32'h0);

    // Allocate and predict
    upd(32'h40, 1, 32'h200);
    redir(32'h40);
    chk("alloc_pt", 32'(bus.pred_taken), 32'h1);
    chk("alloc_tgt", bus.pred_target, 32'h200);
    idle(); chk("alloc_jump", bus.pc, 32'h200);

    // Counter hysteresis
    upd(32'h40, 0, 32'h0);
    redir(32'h40);
    chk("hyst_01", 32'(bus.pred_taken), 32'h0);
    upd(32'h40, 1, 32'h200);
    upd(32'h40, 1, 32'h200);
    upd(32'h40, 0, 32'h0);
    redir(32'h40);
    chk("hyst_10", 32'(bus.pred_taken), 32'h1);

    // Redirect beats stall and prediction
    go(1, 1, 32'h800, 0, 0, 0, 0);
    chk("prio", bus.pc, 32'h800);

    // Aliasing: same index, different tag; lookup sees pre-update state
    redir(32'h40);
    chk("alias_old_pt", 32'(bus.pred_taken), 32'h1);
    chk("alias_old_tgt", bus.pred_target, 32'h200);
    upd(32'h140, 1, 32'h300);
    redir(32'h40);
    chk("alias_miss", 32'(bus.pred_taken), 32'h0);
    redir(32'h140);
    chk("alias_new_pt", 32'(bus.pred_taken), 32'h1);
    chk("alias_new_tgt", bus.pred_target, 32'h300);

    // Mid-run reset, then cold sequential fetches never predict
    do_reset();
    for (int k = 0; k < 64; k++) begin
      chk("cold_pt", 32'(bus.pred_taken), 32'h0);
      idle();
    end
    chk("cold_pc", bus.pc, RPC + 32'd256);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      st  = ($urandom_range(0, 7) == 0);
      rv  = ($urandom_range(0, 5) == 0);
      rpc = pool[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
      uv  = ($urandom_range(0, 2) == 0);
      upc = pool[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
      ut  = 1'($urandom_range(0, 1));
      utg = pool[$urandom_range(0, 9)];
      go(st, rv, rpc, uv, upc, ut, utg);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
